// File: rtl/seq_alu.sv
// Mini-SRC ALU with single-cycle datapath ops and iterative signed mul/div.
// Results land in HI/LO registers; start/done lets the control unit stall.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             IncPC,
    input  logic             branch_flag,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] C_out_HI,
    output logic [WIDTH-1:0] C_out_LO
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_LOADI  = 5'b00001;
    localparam logic [4:0] OP_STORE  = 5'b00010;
    localparam logic [4:0] OP_ADD    = 5'b00011;
    localparam logic [4:0] OP_SUB    = 5'b00100;
    localparam logic [4:0] OP_SHR    = 5'b00101;
    localparam logic [4:0] OP_SHRA   = 5'b00110;
    localparam logic [4:0] OP_SHL    = 5'b00111;
    localparam logic [4:0] OP_ROR    = 5'b01000;
    localparam logic [4:0] OP_ROL    = 5'b01001;
    localparam logic [4:0] OP_AND    = 5'b01010;
    localparam logic [4:0] OP_OR     = 5'b01011;
    localparam logic [4:0] OP_ADDI   = 5'b01100;
    localparam logic [4:0] OP_ANDI   = 5'b01101;
    localparam logic [4:0] OP_ORI    = 5'b01110;
    localparam logic [4:0] OP_MUL    = 5'b01111;
    localparam logic [4:0] OP_DIV    = 5'b10000;
    localparam logic [4:0] OP_NEG    = 5'b10001;
    localparam logic [4:0] OP_NOT    = 5'b10010;
    localparam logic [4:0] OP_BRANCH = 5'b10011;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    function automatic logic [WIDTH-1:0] ror_f(
        input logic [WIDTH-1:0] x,
        input logic [SHW-1:0]   s
    );
        return WIDTH'({x, x} >> s);
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    state_t           state, state_n;
    logic             busy_n, done_n, dz_n;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] mq, mq_n;
    logic [WIDTH-1:0] mb, mb_n;
    logic [WIDTH-1:0] a_r, a_n;
    logic             is_div, is_div_n;
    logic             neg_q, neg_q_n;
    logic             neg_r, neg_r_n;
    logic             b_zero, b_zero_n;

    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   sc_lo;
    logic               is_long;
    logic [WIDTH:0]     m_sum;
    logic [WIDTH:0]     d_sh;
    logic               d_ge;
    logic [2*WIDTH-1:0] prod;

    assign sh      = B[SHW-1:0];
    assign is_long = !IncPC && (opcode == OP_MUL || opcode == OP_DIV);

    always_comb begin
        sc_lo = '0;
        if (IncPC) begin
            sc_lo = A + ONE;
        end else begin
            unique case (opcode)
                OP_LOAD, OP_LOADI, OP_STORE,
                OP_ADD, OP_ADDI:  sc_lo = A + B;
                OP_SUB:           sc_lo = A - B;
                OP_SHR:           sc_lo = A >> sh;
                OP_SHRA:          sc_lo = $signed(A) >>> sh;
                OP_SHL:           sc_lo = A << sh;
                OP_ROR:           sc_lo = ror_f(A, sh);
                OP_ROL:           sc_lo = ror_f(A, -sh);
                OP_AND, OP_ANDI:  sc_lo = A & B;
                OP_OR, OP_ORI:    sc_lo = A | B;
                OP_NEG:           sc_lo = -B;
                OP_NOT:           sc_lo = ~B;
                OP_BRANCH:        sc_lo = branch_flag ? A + B : A;
                default:          sc_lo = '0;
            endcase
        end
    end

    // One shift-add (mul) or restore step (div) on magnitudes
    always_comb begin
        m_sum = {1'b0, acc} + (mq[0] ? {1'b0, mb} : '0);
        d_sh  = {acc, mq[WIDTH-1]};
        d_ge  = d_sh >= {1'b0, mb};
        prod  = {acc, mq};
        if (neg_q) prod = -prod;
    end

    always_comb begin
        state_n  = state;
        busy_n   = busy;
        done_n   = 1'b0;
        dz_n     = div_zero;
        hi_n     = C_out_HI;
        lo_n     = C_out_LO;
        cnt_n    = cnt;
        acc_n    = acc;
        mq_n     = mq;
        mb_n     = mb;
        a_n      = a_r;
        is_div_n = is_div;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        b_zero_n = b_zero;
        unique case (state)
            IDLE: begin
                if (start) begin
                    dz_n = 1'b0;
                    a_n  = A;
                    if (is_long) begin
                        state_n  = ITER;
                        busy_n   = 1'b1;
                        cnt_n    = CW'(WIDTH);
                        acc_n    = '0;
                        mq_n     = mag(A);
                        mb_n     = mag(B);
                        is_div_n = (opcode == OP_DIV);
                        neg_q_n  = A[WIDTH-1] ^ B[WIDTH-1];
                        neg_r_n  = A[WIDTH-1];
                        b_zero_n = (B == '0);
                    end else begin
                        lo_n   = sc_lo;
                        hi_n   = '0;
                        done_n = 1'b1;
                    end
                end
            end
            ITER: begin
                if (is_div) begin
                    acc_n = d_ge ? WIDTH'(d_sh - {1'b0, mb})
                                 : d_sh[WIDTH-1:0];
                    mq_n  = {mq[WIDTH-2:0], d_ge};
                end else begin
                    acc_n = m_sum[WIDTH:1];
                    mq_n  = {m_sum[0], mq[WIDTH-1:1]};
                end
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) state_n = FIX;
            end
            FIX: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                if (!is_div) begin
                    {hi_n, lo_n} = prod;
                end else if (b_zero) begin
                    lo_n = '1;
                    hi_n = a_r;
                    dz_n = 1'b1;
                end else begin
                    lo_n = neg_q ? -mq : mq;
                    hi_n = neg_r ? -acc : acc;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            C_out_HI <= '0;
            C_out_LO <= '0;
            cnt      <= '0;
            acc      <= '0;
            mq       <= '0;
            mb       <= '0;
            a_r      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            b_zero   <= 1'b0;
        end else begin
            state    <= state_n;
            busy     <= busy_n;
            done     <= done_n;
            div_zero <= dz_n;
            C_out_HI <= hi_n;
            C_out_LO <= lo_n;
            cnt      <= cnt_n;
            acc      <= acc_n;
            mq       <= mq_n;
            mb       <= mb_n;
            a_r      <= a_n;
            is_div   <= is_div_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            b_zero   <= b_zero_n;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised scoreboard bench for seq_alu (WIDTH=32) plus a WIDTH=8 instance.
// Expected results come from plain signed arithmetic on 64-bit values.
module tb_seq_alu;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear = 1'b0;
    logic         start = 1'b0;
    logic         IncPC = 1'b0;
    logic         branch_flag = 1'b0;
    logic [4:0]   opcode = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] C_out_HI, C_out_LO;

    logic       clear8 = 1'b0;
    logic       start8 = 1'b0;
    logic       inc8 = 1'b0;
    logic       bf8 = 1'b0;
    logic [4:0] op8 = '0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, dz8;
    logic [7:0] hi8, lo8;

    always #5 clock = ~clock;

    seq_alu #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear), .start(start), .IncPC(IncPC),
        .branch_flag(branch_flag), .opcode(opcode), .A(A), .B(B),
        .busy(busy), .done(done), .div_zero(div_zero),
        .C_out_HI(C_out_HI), .C_out_LO(C_out_LO)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clock(clock), .clear(clear8), .start(start8), .IncPC(inc8),
        .branch_flag(bf8), .opcode(op8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .div_zero(dz8),
        .C_out_HI(hi8), .C_out_LO(lo8)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           passes = 0;
    int           cyc = 0;
    int           busy_from = 1;
    int           busy_to = 0;
    bit           mon_en = 1'b0;
    logic [W-1:0] held_hi = '0;
    logic [W-1:0] held_lo = '0;
    logic         held_dz = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string name,
                                  input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s @cyc %0d: got %h expected %h",
                      name, cyc, act, exp);
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x,
                                          input int s);
        logic [W-1:0] r;
        r = x;
        for (int i = 0; i < s; i++) r = {r[0], r[W-1:1]};
        return r;
    endfunction

    function automatic void model(input logic [4:0] op,
                                  input logic [W-1:0] a, b,
                                  input logic inc, bf,
                                  output logic [W-1:0] hi, lo,
                                  output logic dz, output bit lng);
        longint sa, sb_v, p, qq, rr;
        int     s;
        hi = '0; lo = '0; dz = 1'b0; lng = 1'b0;
        s = int'(b[4:0]);
        sa = longint'($signed(a));
        sb_v = longint'($signed(b));
        if (inc) lo = a + 1;
        else case (op)
            0, 1, 2, 3, 12: lo = a + b;
            4:  lo = a - b;
            5:  lo = a >> s;
            6:  lo = $signed(a) >>> s;
            7:  lo = a << s;
            8:  lo = rotr(a, s);
            9:  lo = rotr(a, (W - s) % W);
            10, 13: lo = a & b;
            11, 14: lo = a | b;
            15: begin
                lng = 1'b1;
                p = sa * sb_v;
                {hi, lo} = p;
            end
            16: begin
                lng = 1'b1;
                if (b == '0) begin
                    lo = '1; hi = a; dz = 1'b1;
                end else begin
                    qq = sa / sb_v;
                    rr = sa % sb_v;
                    lo = qq[W-1:0];
                    hi = rr[W-1:0];
                end
            end
            17: lo = -b;
            18: lo = ~b;
            19: lo = bf ? a + b : a;
            default: ;
        endcase
    endfunction

    always @(negedge clock) begin
        if (mon_en) begin
            exp_t e;
            logic exp_done;
            exp_done = (sb.size() != 0) && (sb[0].due == cyc);
            check("done", done, exp_done);
            if (done && sb.size() != 0) begin
                e = sb.pop_front();
                held_hi = e.hi;
                held_lo = e.lo;
                held_dz = e.dz;
            end
            check("busy", busy, (cyc >= busy_from) && (cyc <= busy_to));
            check("hi", C_out_HI, held_hi);
            check("lo", C_out_LO, held_lo);
            check("div_zero", div_zero, held_dz);
        end
    end

    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, b,
                         input logic inc, bf, input bit noise,
                         input logic [W-1:0] eh, el,
                         input logic edz, input bit lng);
        int n = 0;
        @(negedge clock);
        while (busy && n < 200) begin
            if (noise) begin
                start  = 1'($urandom_range(0, 1));
                opcode = 5'($urandom);
                A      = $urandom;
                B      = $urandom;
                IncPC  = 1'($urandom_range(0, 1));
            end
            n++;
            @(negedge clock);
        end
        check("idle_wait", busy, 1'b0);
        opcode = op; A = a; B = b; IncPC = inc; branch_flag = bf;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        held_dz = 1'b0;
        if (lng) begin
            sb.push_back('{eh, el, edz, cyc + W + 1});
            busy_from = cyc;
            busy_to   = cyc + W;
        end else begin
            sb.push_back('{eh, el, edz, cyc});
        end
    endtask

    task automatic issue_rand(input logic [4:0] op, input logic [W-1:0] a, b,
                              input logic inc, bf, input bit noise);
        logic [W-1:0] eh, el;
        logic         edz;
        bit           lng;
        model(op, a, b, inc, bf, eh, el, edz, lng);
        issue(op, a, b, inc, bf, noise, eh, el, edz, lng);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 1) ? W'($urandom_range(0, 20))
                                           : -W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic run8(input logic [4:0] op, input logic [7:0] a, b,
                        input logic bf, output int lat);
        int k;
        @(negedge clock);
        op8 = op; a8 = a; b8 = b; bf8 = bf; start8 = 1'b1;
        @(posedge clock);
        #1;
        start8 = 1'b0;
        k = cyc;
        lat = 0;
        @(negedge clock);
        while (!done8 && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        lat = cyc - k;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           lat;
        logic [4:0]   op;
        logic [W-1:0] tmp;
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dz", div_zero, 1'b0);
        check("rst_hi", C_out_HI, '0);
        check("rst_lo", C_out_LO, '0);
        clear = 1'b1;
        clear8 = 1'b1;
        mon_en = 1'b1;

        issue(5'd3, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, '0, '0, 0, 0);
        issue(5'd4, 32'h10, 32'h0, 1, 0, 0, '0, 32'h11, 0, 0);
        issue(5'd6, 32'h8000_0000, 32'h24, 0, 0, 0, '0, 32'hF800_0000, 0, 0);
        issue(5'd9, 32'h8000_0001, 32'h1, 0, 0, 0, '0, 32'h3, 0, 0);
        issue(5'd15, -32'sd3, 32'd7, 0, 0, 1,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 1);
        issue(5'd16, -32'sd17, 32'd5, 0, 0, 1,
              32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 1);
        issue(5'd16, 32'd9, 32'd0, 0, 0, 0, 32'd9, 32'hFFFF_FFFF, 1, 1);
        issue(5'd3, 32'd1, 32'd2, 0, 0, 0, '0, 32'd3, 0, 0);
        issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0,
              '0, 32'h8000_0000, 0, 1);
        issue(5'd19, 32'h20, 32'h55, 0, 0, 0, '0, 32'h20, 0, 0);
        issue(5'd19, 32'h20, 32'h55, 0, 1, 0, '0, 32'h75, 0, 0);
        issue(5'd25, 32'h1234, 32'h5678, 0, 0, 0, '0, '0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            op = 5'($urandom_range(0, 23));
            if ($urandom_range(0, 3) == 0) op = $urandom_range(0, 1) ? 5'd15 : 5'd16;
            tmp = pick();
            issue_rand(op, tmp, pick(), ($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();

        issue_rand(5'd15, 32'd123, 32'd456, 0, 0, 0);
        repeat (9) @(posedge clock);
        #2;
        clear = 1'b0;
        sb.delete();
        busy_from = 1;
        busy_to = 0;
        held_hi = '0;
        held_lo = '0;
        held_dz = 1'b0;
        #1;
        check("abort_hi", C_out_HI, '0);
        check("abort_lo", C_out_LO, '0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        repeat (3) @(negedge clock);
        clear = 1'b1;
        repeat (40) @(negedge clock);
        issue(5'd4, 32'd5, 32'd7, 0, 0, 0, '0, 32'hFFFF_FFFE, 0, 0);
        drain();

        run8(5'd15, 8'h7F, 8'h7F, 0, lat);
        check("w8_mul_lat", lat, 9);
        check("w8_mul_hi", hi8, 8'h3F);
        check("w8_mul_lo", lo8, 8'h01);
        run8(5'd19, 8'h20, 8'h55, 0, lat);
        check("w8_br_lat", lat, 0);
        check("w8_br_lo", lo8, 8'h20);
        check("w8_br_hi", hi8, 8'h00);
        check("w8_br_busy", busy8, 1'b0);
        run8(5'd16, 8'h80, 8'hFF, 0, lat);
        check("w8_div_lat", lat, 9);
        check("w8_div_lo", lo8, 8'h80);
        check("w8_div_hi", hi8, 8'h00);
        check("w8_div_dz", dz8, 1'b0);

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath ALU for the Mini-SRC CPU.
- Single-cycle ops (add/sub/logic/shift/rotate/neg/not/branch/IncPC) complete one clock after start.
- Mul (signed, radix-2 shift-add) and div (signed, restoring) are iterative, one bit per cycle.
- A start/done handshake lets the control unit stall on long ops. Results are registered into the HI/LO outputs that feed the Z register.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two, 8..64.
- SHW, $clog2(WIDTH), localparam; number of B bits used as shift/rotate amount.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- IncPC  in  1  overrides opcode: C_out_LO = A+1.
- branch_flag  in  1  branch-taken condition for the Branch opcode.
- opcode  in  5  Mini-SRC opcode encoding, identical to the existing ALU: Add/Load/Loadi/Store/Addi=00011/00000/00001/00010/01100, Sub=00100, Shr=00101, Shra=00110, Shl=00111, Ror=01000, Rol=01001, And/Andi=01010/01101, Or/Ori=01011/01110, Mul=01111, Div=10000, Neg=10001, Not=10010, Branch=10011.
- A  in  WIDTH  operand A (Y register).
- B  in  WIDTH  operand B (bus / immediate).
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- div_zero  out  1  set with done when Div had B==0; cleared on next accepted start.
- C_out_HI  out  WIDTH  high result (mul high word / div remainder).
- C_out_LO  out  WIDTH  low result.

Behaviour:
- Reset: asynchronous on clear=0. State=IDLE; busy, done, div_zero=0; C_out_HI, C_out_LO=0; iteration counter and working registers=0. Reset mid-operation aborts it with no done pulse.
- States: IDLE, ITER, FIX.
- IDLE with start=1 (edge k): latch A, B, opcode, IncPC, branch_flag. Clear div_zero.
  - Single-cycle op: outputs written at edge k. done=1 for cycle k..k+1. State stays IDLE; busy never asserts.
  - Mul/Div: busy=1, counter=WIDTH, next state ITER.
- ITER: one iteration per edge, counter decrements. At counter==1 the next state is FIX.
- FIX: sign correction; outputs written. done=1 for exactly one cycle. busy=0. Next state IDLE.
- Mul/Div latency: done is high in the cycle after edge k+WIDTH+1.
- start while busy=1 is ignored. start is also legal in the cycle done is high; the new op is accepted.
- Outputs hold their last value between operations. done=0 whenever no completion occurs.
- Single-cycle results (HI=0 unless stated):
  - Add: A+B mod 2^WIDTH, carry discarded.
  - Sub: A-B.
  - Shr: logical right by B[SHW-1:0]. Shra: arithmetic right. Shl: left.
  - Ror/Rol: rotate by B[SHW-1:0] modulo WIDTH.
  - And/Or: bitwise.
  - Neg: -B (two's complement). Not: ~B.
  - Branch: A+B if branch_flag else A.
  - IncPC=1: A+1, regardless of opcode.
  - Undefined opcode: LO=0, HI=0; done still pulses.
- Mul: signed A*B, 2*WIDTH-bit product. HI = upper half, LO = lower half. Magnitudes are multiplied; the product is negated in FIX if signs differ.
- Div: signed, truncating toward zero. LO = quotient, HI = remainder, remainder takes the sign of A.
  - B==0: full latency preserved. LO = all ones, HI = A, div_zero=1 with done.
  - Most-negative / -1: LO = most-negative, HI = 0 (wraps, no flag).

Test Plan:
- WIDTH=32, Add A=0xFFFFFFFF B=1 start -> done next cycle, LO=0, HI=0, busy never high. IncPC=1, A=0x10 -> LO=0x11.
- Shra A=0x80000000 B=0x24 (shift 4) -> LO=0xF8000000. Rol A=0x80000001 B=1 -> LO=0x00000003.
- Mul A=-3 B=7 -> done exactly 33 cycles after the start edge, HI=0xFFFFFFFF, LO=0xFFFFFFEB. busy high throughout. start pulses during busy are ignored.
- Div A=-17 B=5 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFE (-2). Div A=9 B=0 -> LO=0xFFFFFFFF, HI=9, div_zero=1; next Add start clears div_zero.
- Reset: clear low mid-Mul (cycle 10) -> all outputs 0 immediately, no done. After release, Sub A=5 B=7 -> LO=0xFFFFFFFE.
- WIDTH=8 instance: Mul A=0x7F B=0x7F -> done after 9 cycles, HI=0x3F, LO=0x01. Branch with flag=0, A=0x20 -> LO=0x20.
